pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage 16-bit pipeline.
//  Drives the hold (enable) and bubble (flush) controls of the PC and the F2D, D2X, X2M and M2W pipeline registers.
//  Inputs: load-use hazards, taken branches/jumps resolved in X, multi-cycle data memory in M, instruction fetch stalls, HALT.
//  Assumes X->X and M->X forwarding exist, so only load-use RAW hazards stall.
// PARAMETERS
//  MAX_WAIT  15  max consecutive MEM_WAIT cycles before memErr sets (1..255)
//  CNT_W     16  width of the perf counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1  clock, all state updates on rising edge
//  rst           in   1  asynchronous, active-low reset
//  readReg1D     in   3  decode source reg 1
//  readReg2D     in   3  decode source reg 2
//  useReg1D      in   1  decode instr reads readReg1D
//  useReg2D      in   1  decode instr reads readReg2D
//  readEnX       in   1  instr in X is a load
//  regWrtX       in   1  instr in X writes a register
//  wrtRegX       in   3  dest reg of instr in X
//  branchTakenX  in   1  X resolved a taken branch/jump (PC redirect)
//  memReqM       in   1  instr in M accesses dmem (readEn|memWrt)
//  memDoneM      in   1  dmem access complete this cycle
//  imemStallF    in   1  fetch has no valid instruction this cycle
//  haltM         in   1  HALT instr in M
//  pcEn          out  1  PC register load enable
//  f2dEn / d2xEn / x2mEn / m2wEn   out 1 each   pipe reg load enable
//  f2dFlush / d2xFlush / m2wFlush  out 1 each   load a NOP bubble instead of d
//  memErr        out  1  sticky: MEM_WAIT exceeded MAX_WAIT
// BEHAVIOUR
//  FSM: RUN, MEM_WAIT, HALTED. Outputs are combinational from state + inputs. Flush acts only with its en=1.
//  rst low: state=RUN, waitCnt=0, memErr=0, all en=0, all flush=0.
//  RUN, priority high->low:
//   1 haltM: all en=0 -> HALTED (haltM's own memory access is ignored).
//   2 memReqM & !memDoneM: pcEn=f2dEn=d2xEn=x2mEn=0; m2wEn=1, m2wFlush=1 -> MEM_WAIT, waitCnt=1.
//   3 branchTakenX: all en=1; f2dFlush=d2xFlush=1 (2 squashed instrs); load-use and imemStallF ignored.
//   4 loadUse = readEnX & regWrtX & ((useReg1D & readReg1D==wrtRegX) | (useReg2D & readReg2D==wrtRegX)).
//     Holds pcEn=f2dEn=0; d2xEn=1, d2xFlush=1; x2mEn=m2wEn=1. Stall length: exactly 1 cycle.
//     R0 is a normal register: no special case.
//   5 imemStallF: pcEn=0; f2dEn=1, f2dFlush=1; d2xEn=x2mEn=m2wEn=1.
//   6 else: all en=1, no flush.
//  MEM_WAIT: same outputs as RUN case 2, until memDoneM.
//   On memDoneM: all en=1; the lower-priority RUN rules apply in that same cycle; -> RUN, waitCnt=0.
//   Otherwise waitCnt++ (saturating). waitCnt==MAX_WAIT & !memDoneM sets memErr; the FSM keeps waiting.
//   branchTakenX during MEM_WAIT is held by the frozen X2M/D2X and acts on the exit cycle.
//  HALTED: all en=0, all flush=0. Exit only via reset. memErr clears only via reset.
//  Reset mid-MEM_WAIT: immediate RUN, counters cleared, no outstanding-state carry-over.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//   - adds outputs stallCnt[CNT_W-1:0] (cycles with pcEn=0 in RUN/MEM_WAIT) and flushCnt[CNT_W-1:0] (branch redirects).
//   - Both counters saturate at all-ones and clear on reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package pipe_ctrl_pkg: state encodings (RUN=2'b00, MEM_WAIT=2'b01, HALTED=2'b10), waitCnt width localparam.
//  Sub-module load_use_det (combinational loadUse compare), instanced once.
//  FSM, waitCnt and perf counters live in pipe_hazard_ctrl.
// TESTING
//  1 Load r3 in X, D reads r3 on reg2 -> 1 cycle: pcEn=0, f2dEn=0, d2xFlush=1; next cycle all en=1.
//  2 memReqM=1, memDoneM low for 3 cycles -> pcEn=x2mEn=0 and m2wFlush=1 for 3 cycles.
//    Cycle 4 memDoneM=1 -> all en=1, state RUN.
//  3 branchTakenX=1 with loadUse=1 and imemStallF=1 -> pcEn=1, f2dFlush=d2xFlush=1, no hold.
//  4 memDoneM held low 16 cycles (MAX_WAIT=15) -> memErr=1 at the 15th wait cycle and stays 1.
//    Later memDoneM -> RUN, memErr stays 1.
//  5 haltM=1 -> all en=0 forever despite other stimulus; rst low then high -> RUN, memErr=0.
//  6 PIPE_PERF_CNT_EN, CNT_W=4: 20 imem stall cycles -> stallCnt=4'hF; 2 branches -> flushCnt=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_ctrl_pkg;

    // Architectural register index width (8 GPRs)
    localparam int REG_W  = 3;
    // Memory-wait counter width; covers MAX_WAIT up to 255
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALTED   = 2'b10
    } state_t;

    // Pipeline control bundle; bit order is the same everywhere it is packed
    typedef struct packed {
        logic pc_en;
        logic f2d_en;
        logic d2x_en;
        logic x2m_en;
        logic m2w_en;
        logic f2d_flush;
        logic d2x_flush;
        logic m2w_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD     = 8'b00000_000;
    localparam ctrl_t CTRL_RUN      = 8'b11111_000;
    localparam ctrl_t CTRL_MEM_WAIT = 8'b00001_001;
    localparam ctrl_t CTRL_BRANCH   = 8'b11111_110;
    localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
    localparam ctrl_t CTRL_IMEM     = 8'b01111_100;

    // Controls chosen once the memory stage is not blocking: redirect beats
    // load-use, which beats a fetch bubble.
    function automatic ctrl_t run_rules(input logic branch,
                                        input logic load_use,
                                        input logic imem_stall);
        ctrl_t c;
        if (branch)          c = CTRL_BRANCH;
        else if (load_use)   c = CTRL_LOAD_USE;
        else if (imem_stall) c = CTRL_IMEM;
        else                 c = CTRL_RUN;
        return c;
    endfunction

endpackage

// File: rtl/load_use_det.sv
// Load-use RAW hazard compare between the decode sources and a load in X.
// Latency: purely combinational.
// Backpressure: none; result feeds the hazard sequencer directly.
module load_use_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_read_reg1,
    input  logic [REG_W-1:0] i_read_reg2,
    input  logic             i_use_reg1,
    input  logic             i_use_reg2,
    input  logic             i_read_en_x,
    input  logic             i_reg_wrt_x,
    input  logic [REG_W-1:0] i_wrt_reg_x,
    output logic             o_load_use
);

    logic w_hit1;
    logic w_hit2;

    // R0 is an ordinary register here, so no zero-index exclusion
    always_comb begin
        w_hit1     = i_use_reg1 && (i_read_reg1 == i_wrt_reg_x);
        w_hit2     = i_use_reg2 && (i_read_reg2 == i_wrt_reg_x);
        o_load_use = i_read_en_x && i_reg_wrt_x && (w_hit1 || w_hit2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; optional perf counters under PIPE_PERF_CNT_EN.
// Latency: controls are combinational from state + inputs; state/counters update on clk rise.
// Backpressure: a pending data-memory access freezes PC..X2M and bubbles M2W until memDoneM.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] readReg1D,
    input  logic [REG_W-1:0] readReg2D,
    input  logic             useReg1D,
    input  logic             useReg2D,
    input  logic             readEnX,
    input  logic             regWrtX,
    input  logic [REG_W-1:0] wrtRegX,
    input  logic             branchTakenX,
    input  logic             memReqM,
    input  logic             memDoneM,
    input  logic             imemStallF,
    input  logic             haltM,
    output logic             pcEn,
    output logic             f2dEn,
    output logic             d2xEn,
    output logic             x2mEn,
    output logic             m2wEn,
    output logic             f2dFlush,
    output logic             d2xFlush,
    output logic             m2wFlush,
    output logic             memErr
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
`endif
);

    // Reject out-of-range configurations at elaboration
    if (MAX_WAIT < 1 || MAX_WAIT > 255 || CNT_W < 1) begin : g_param_chk
        $error("pipe_hazard_ctrl: MAX_WAIT must be 1..255 and CNT_W >= 1");
    end

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_err;

    logic                w_load_use;
    logic                w_mem_block;
    logic                w_err_set;
    logic                w_redirect;
    ctrl_t               w_ctrl;
    ctrl_t               w_ctrl_out;

    load_use_det u_load_use_det (
        .i_read_reg1 (readReg1D),
        .i_read_reg2 (readReg2D),
        .i_use_reg1  (useReg1D),
        .i_use_reg2  (useReg2D),
        .i_read_en_x (readEnX),
        .i_reg_wrt_x (regWrtX),
        .i_wrt_reg_x (wrtRegX),
        .o_load_use  (w_load_use)
    );

    // Select the pipeline controls for this cycle from state and hazards
    always_comb begin
        w_ctrl      = CTRL_HOLD;
        w_err_set   = 1'b0;
        w_redirect  = 1'b0;
        w_mem_block = memReqM && !memDoneM;
        case (r_state)
            ST_RUN: begin
                if (haltM) begin
                    w_ctrl = CTRL_HOLD;
                end else if (w_mem_block) begin
                    w_ctrl = CTRL_MEM_WAIT;
                end else begin
                    w_ctrl     = run_rules(branchTakenX, w_load_use, imemStallF);
                    w_redirect = branchTakenX;
                end
            end
            ST_MEM_WAIT: begin
                // A branch held in the frozen X stage takes effect on the exit cycle
                if (memDoneM) begin
                    w_ctrl     = run_rules(branchTakenX, w_load_use, imemStallF);
                    w_redirect = branchTakenX;
                end else begin
                    w_ctrl    = CTRL_MEM_WAIT;
                    w_err_set = (r_wait_cnt == WAIT_W'(MAX_WAIT));
                end
            end
            default: begin
                w_ctrl = CTRL_HOLD;
            end
        endcase
    end

    // Hold everything quiet while reset is asserted
    always_comb begin
        w_ctrl_out = rst ? w_ctrl : CTRL_HOLD;
        pcEn       = w_ctrl_out.pc_en;
        f2dEn      = w_ctrl_out.f2d_en;
        d2xEn      = w_ctrl_out.d2x_en;
        x2mEn      = w_ctrl_out.x2m_en;
        m2wEn      = w_ctrl_out.m2w_en;
        f2dFlush   = w_ctrl_out.f2d_flush;
        d2xFlush   = w_ctrl_out.d2x_flush;
        m2wFlush   = w_ctrl_out.m2w_flush;
        // Error shows in the cycle the limit is reached, then stays via the sticky flop
        memErr     = rst && (r_mem_err || w_err_set);
    end

    // Sequencer FSM with memory-wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (haltM) begin
                        r_state <= ST_HALTED;
                    end else if (w_mem_block) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (memDoneM) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        if (r_wait_cnt != '1) begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                        if (w_err_set) begin
                            r_mem_err <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of PC-hold cycles (outside HALTED) and branch redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != ST_HALTED) && !w_ctrl.pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;
`endif

endmodule
